// File: rtl/bcd_seven_seg_driver_pkg.sv
// Shared constants, state encoding and nibble decode for the BCD display driver.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0011000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

    // Nibbles 10..15 cannot come out of a correct conversion; show them as '0'.
    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        case (nibble)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_0;
        endcase
    endfunction

endpackage

// File: rtl/bcd_seven_seg_driver_if.sv
// Handshake and display bus between a value producer and the BCD display driver.
interface bcd_seven_seg_driver_if #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      num;
    logic                  done;
    logic                  overflow;
    logic [7*DIGITS-1:0]   seven_segs;

    modport master (output in_valid, num, input in_ready, done, overflow, seven_segs);
    modport slave  (input in_valid, num, output in_ready, done, overflow, seven_segs);
endinterface

// File: rtl/bcd_seven_seg_driver_seg7_decode.sv
// Combinational BCD nibble to active-low 7-segment pattern.
module seg7_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Pure lookup through the shared package decode function.
    always_comb begin
        seg = seg_decode(nibble);
    end

endmodule

// File: rtl/bcd_seven_seg_driver.sv
// Sequential binary-to-BCD display driver: iterative double-dabble, one input
// bit per clock, then one cycle to register the decoded digit patterns.
// Build option: define SEVSEG_LZ_BLANK_EN to blank leading zero digits.
module bcd_seven_seg_driver
    import seven_seg_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 3
)(
    input  logic                   clk,
    input  logic                   rst,
    bcd_seven_seg_driver_if.slave  bus
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH);

    // Display pattern after reset: '0' on every digit, or only on digit 0 when blanking.
    function automatic logic [7*DIGITS-1:0] reset_segs();
        logic [7*DIGITS-1:0] r;
        for (int k = 0; k < DIGITS; k++) begin
            r[7*k +: 7] = SEG_0;
`ifdef SEVSEG_LZ_BLANK_EN
            if (k > 0) r[7*k +: 7] = SEG_BLANK;
`endif
        end
        return r;
    endfunction

    localparam logic [7*DIGITS-1:0] RESET_SEGS = reset_segs();

    state_t              state;
    logic [WIDTH-1:0]    shift_reg;
    logic [BW-1:0]       bcd;
    logic [CW-1:0]       bit_cnt;
    logic                ovf_sticky;
    logic                in_ready_q;
    logic                done_q;
    logic                overflow_q;
    logic [7*DIGITS-1:0] segs_q;

    logic [BW-1:0]       bcd_adj;
    logic [BW-1:0]       bcd_next;
    logic [WIDTH-1:0]    shift_next;
    logic                carry_out;
    logic                ovf_final;
    logic [7*DIGITS-1:0] decoded;
    logic [7*DIGITS-1:0] display;

    // One double-dabble step: bump every nibble >= 5 by 3, then shift the whole
    // BCD:binary chain left; whatever leaves the top nibble means the value no longer fits.
    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
        end
        carry_out  = bcd_adj[BW-1];
        bcd_next   = {bcd_adj[BW-2:0], shift_reg[WIDTH-1]};
        shift_next = {shift_reg[WIDTH-2:0], 1'b0};
        ovf_final  = ovf_sticky | (bcd[BW-1 -: 4] >= 4'd10);
    end

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_dec
            seg7_decode u_dec (
                .nibble (bcd[4*g +: 4]),
                .seg    (decoded[7*g +: 7])
            );
        end
    endgenerate

`ifdef SEVSEG_LZ_BLANK_EN
    logic [DIGITS-1:0] blank;
    logic              zero_run;

    // A digit is blanked while it and every digit above it are zero; digit 0 never blanks.
    always_comb begin
        blank    = '0;
        zero_run = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_run = zero_run & (bcd[4*k +: 4] == 4'd0);
            blank[k] = zero_run;
        end
    end
`endif

    // Assemble the pattern to latch at UPDATE: dashes on overflow, otherwise digits.
    always_comb begin
        display = decoded;
`ifdef SEVSEG_LZ_BLANK_EN
        for (int k = 0; k < DIGITS; k++) begin
            if (blank[k]) display[7*k +: 7] = SEG_BLANK;
        end
`endif
        if (ovf_final) display = {DIGITS{SEG_DASH}};
    end

    // Control FSM with datapath: accept in IDLE, shift WIDTH times in CONV, publish in UPDATE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bcd        <= '0;
            bit_cnt    <= '0;
            ovf_sticky <= 1'b0;
            in_ready_q <= 1'b1;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            segs_q     <= RESET_SEGS;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        shift_reg  <= bus.num;
                        bcd        <= '0;
                        ovf_sticky <= 1'b0;
                        bit_cnt    <= CW'(WIDTH - 1);
                        in_ready_q <= 1'b0;
                        state      <= CONV;
                    end
                end
                CONV: begin
                    bcd        <= bcd_next;
                    shift_reg  <= shift_next;
                    ovf_sticky <= ovf_sticky | carry_out;
                    if (bit_cnt == '0) begin
                        state <= UPDATE;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                UPDATE: begin
                    segs_q     <= display;
                    overflow_q <= ovf_final;
                    done_q     <= 1'b1;
                    in_ready_q <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.done       = done_q;
    assign bus.overflow   = overflow_q;
    assign bus.seven_segs = segs_q;

endmodule

// File: tb/tb_bcd_seven_seg_driver.sv
// Directed bench for bcd_seven_seg_driver: a 32-bit/3-digit instance driven from
// a vector table plus hand sequences, and a 4-bit/2-digit instance for the small case.
module tb_bcd_seven_seg_driver;

`ifdef SEVSEG_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    localparam logic [6:0] T0 = 7'b1000000;
    localparam logic [6:0] T1 = 7'b1111001;
    localparam logic [6:0] T2 = 7'b0100100;
    localparam logic [6:0] T3 = 7'b0110000;
    localparam logic [6:0] T4 = 7'b0011001;
    localparam logic [6:0] T5 = 7'b0010010;
    localparam logic [6:0] T6 = 7'b0000010;
    localparam logic [6:0] T7 = 7'b1111000;
    localparam logic [6:0] T8 = 7'b0000000;
    localparam logic [6:0] T9 = 7'b0011000;
    localparam logic [6:0] TB_ = 7'b1111111;
    localparam logic [6:0] TD = 7'b0111111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bcd_seven_seg_driver_if #(.WIDTH(32), .DIGITS(3)) bus ();
    bcd_seven_seg_driver #(.WIDTH(32), .DIGITS(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    bcd_seven_seg_driver_if #(.WIDTH(4), .DIGITS(2)) bus_s ();
    bcd_seven_seg_driver #(.WIDTH(4), .DIGITS(2)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    typedef struct {
        string       name;
        logic [31:0] num;
        logic [20:0] segs;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   acceptLog[$];

    // Log the cycle number of every accepted handshake on the wide instance.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && bus.in_valid && bus.in_ready) acceptLog.push_back(cyc);
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic waitDone(output int lat);
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic applyStimulus(input logic [31:0] value, output int lat);
        @(negedge clk);
        for (int n = 0; n < 100 && !bus.in_ready; n++) @(negedge clk);
        bus.num      = value;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        waitDone(lat);
    endtask

    initial begin
        int lat;
        int firstAcc;
        int doneCount;
        int accCount;
        logic [20:0] held;

        bus.in_valid   = 1'b0;
        bus.num        = '0;
        bus_s.in_valid = 1'b0;
        bus_s.num      = '0;

        vecs.push_back('{"v123",  32'd123,  {T1, T2, T3}, 1'b0});
        vecs.push_back('{"v999",  32'd999,  {T9, T9, T9}, 1'b0});
        vecs.push_back('{"v1000", 32'd1000, {TD, TD, TD}, 1'b1});
        vecs.push_back('{"v0",    32'd0,    LZ ? {TB_, TB_, T0} : {T0, T0, T0}, 1'b0});
        vecs.push_back('{"v7",    32'd7,    LZ ? {TB_, TB_, T7} : {T0, T0, T7}, 1'b0});
        vecs.push_back('{"v80",   32'd80,   LZ ? {TB_, T8, T0} : {T0, T8, T0}, 1'b0});
        vecs.push_back('{"v105",  32'd105,  {T1, T0, T5}, 1'b0});
        vecs.push_back('{"v456",  32'd456,  {T4, T5, T6}, 1'b0});
        vecs.push_back('{"vmax",  32'hFFFF_FFFF, {TD, TD, TD}, 1'b1});

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset in_ready", bus.in_ready, 1'b1);
        checkOutput("reset done", bus.done, 1'b0);
        checkOutput("reset overflow", bus.overflow, 1'b0);
        checkOutput("reset segs", bus.seven_segs, LZ ? {TB_, TB_, T0} : {T0, T0, T0});
        checkOutput("reset small segs", bus_s.seven_segs, LZ ? {TB_, T0} : {T0, T0});
        rst = 1'b0;

        // Table-driven conversions
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].num, lat);
            checkOutput({vecs[i].name, " latency"}, lat, 33);
            checkOutput({vecs[i].name, " segs"}, bus.seven_segs, vecs[i].segs);
            checkOutput({vecs[i].name, " overflow"}, bus.overflow, vecs[i].ovf);
            checkOutput({vecs[i].name, " in_ready"}, bus.in_ready, 1'b1);
            @(posedge clk);
            #1;
            checkOutput({vecs[i].name, " done pulse"}, bus.done, 1'b0);
            repeat (3) @(posedge clk);
            #1;
            checkOutput({vecs[i].name, " held segs"}, bus.seven_segs, vecs[i].segs);
        end

        // in_valid held high: 5 then 42, change of num during CONV is ignored
        acceptLog.delete();
        @(negedge clk);
        bus.num      = 32'd5;
        bus.in_valid = 1'b1;
        for (int n = 0; n < 10 && acceptLog.size() < 1; n++) @(negedge clk);
        checkOutput("held first accept", acceptLog.size(), 1);
        bus.num = 32'd42;
        @(negedge clk);
        checkOutput("held in_ready in CONV", bus.in_ready, 1'b0);
        waitDone(lat);
        checkOutput("held segs 5", bus.seven_segs, LZ ? {TB_, TB_, T5} : {T0, T0, T5});
        for (int n = 0; n < 10 && acceptLog.size() < 2; n++) @(negedge clk);
        checkOutput("held second accept", acceptLog.size(), 2);
        if (acceptLog.size() >= 2) checkOutput("held accept spacing", acceptLog[1] - acceptLog[0], 34);
        bus.in_valid = 1'b0;
        waitDone(lat);
        checkOutput("held segs 042", bus.seven_segs, LZ ? {TB_, T4, T2} : {T0, T4, T2});
        repeat (40) @(posedge clk);
        checkOutput("held accept count", acceptLog.size(), 2);

        // Reset during conversion of 456, after an overflow display
        applyStimulus(32'd1000, lat);
        checkOutput("pre-reset overflow", bus.overflow, 1'b1);
        accCount = acceptLog.size();
        @(negedge clk);
        bus.num      = 32'd456;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checkOutput("abort accepted", acceptLog.size(), accCount + 1);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort in_ready", bus.in_ready, 1'b1);
        checkOutput("abort done", bus.done, 1'b0);
        checkOutput("abort overflow", bus.overflow, 1'b0);
        checkOutput("abort segs", bus.seven_segs, LZ ? {TB_, TB_, T0} : {T0, T0, T0});
        doneCount = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) doneCount++;
        end
        checkOutput("abort no done", doneCount, 0);
        applyStimulus(32'd456, lat);
        checkOutput("after abort latency", lat, 33);
        checkOutput("after abort segs", bus.seven_segs, {T4, T5, T6});

        // Narrow instance: WIDTH=4, DIGITS=2
        @(negedge clk);
        bus_s.num      = 4'd15;
        bus_s.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_s.in_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (bus_s.done) begin
                lat = n;
                break;
            end
        end
        checkOutput("small 15 latency", lat, 5);
        checkOutput("small 15 segs", bus_s.seven_segs, {T1, T5});
        checkOutput("small 15 overflow", bus_s.overflow, 1'b0);

        @(negedge clk);
        bus_s.num      = 4'd9;
        bus_s.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_s.in_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (bus_s.done) begin
                lat = n;
                break;
            end
        end
        checkOutput("small 9 latency", lat, 5);
        checkOutput("small 9 segs", bus_s.seven_segs, LZ ? {TB_, T9} : {T0, T9});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
